// File: rtl/layer1_disc_stream_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : layer1_disc_stream_adapter_if
// Brief    : valid/ready/last element stream used on both sides of the adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface layer1_disc_stream_adapter_if #(
    parameter int W = 16
);
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/layer1_disc_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : layer1_disc_stream_adapter
// Brief    : packs a sample frame for the first dense layer, kicks it, and
//            replays the captured result as a stream.
// Revision : 1.0 - initial release
// ============================================================================
module layer1_disc_stream_adapter #(
    parameter int IN_N    = 256,
    parameter int OUT_N   = 128,
    parameter int W       = 16,
    parameter int TIMEOUT = 40000
) (
    input  wire                  clk,
    input  wire                  rst,
    layer1_disc_stream_adapter_if.slave  s,
    layer1_disc_stream_adapter_if.master m,
    output logic [W*IN_N-1:0]    layer_input_flat,
    output logic                 layer_start,
    input  wire  [W*OUT_N-1:0]   layer_output_flat,
    input  wire                  layer_done,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int IW = (IN_N  > 1) ? $clog2(IN_N)  : 1;
    localparam int OW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_KICK  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t         r_state, w_state;
    logic [IW-1:0]  r_in_idx, w_in_idx;
    logic [OW-1:0]  r_out_idx, w_out_idx;
    logic [TW-1:0]  r_wdog, w_wdog;
    logic           r_s_ready, w_s_ready;
    logic           r_start, w_start;
    logic           r_m_valid, w_m_valid;
    logic [W-1:0]   r_m_data, w_m_data;
    logic           r_m_last, w_m_last;
    logic           r_busy, w_busy;
    logic           r_err, w_err;
    logic           w_in_we, w_cap;

    logic [W-1:0]   r_in_buf  [IN_N];
    logic [W-1:0]   r_out_buf [OUT_N];
    logic [W-1:0]   w_out_elem [OUT_N];

    // The input buffer drives the layer directly so it stays stable while the layer runs.
    for (genvar k = 0; k < IN_N; k++) begin : g_pack
        assign layer_input_flat[W*k +: W] = r_in_buf[k];
    end

    for (genvar j = 0; j < OUT_N; j++) begin : g_unpack
        assign w_out_elem[j] = layer_output_flat[W*j +: W];
    end

    always_comb begin
        w_state   = r_state;
        w_in_idx  = r_in_idx;
        w_out_idx = r_out_idx;
        w_wdog    = r_wdog;
        w_s_ready = r_s_ready;
        w_start   = 1'b0;
        w_m_valid = r_m_valid;
        w_m_data  = r_m_data;
        w_m_last  = r_m_last;
        w_err     = 1'b0;
        w_in_we   = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_s_ready = 1'b1;
                if (s.valid && r_s_ready) begin
                    w_in_we = 1'b1;
                    if (r_in_idx == IW'(IN_N - 1)) begin
                        // A full frame proceeds even if last was missing on its final beat.
                        w_state   = ST_KICK;
                        w_in_idx  = '0;
                        w_s_ready = 1'b0;
                        w_start   = 1'b1;
                        w_err     = !s.last;
                    end else if (s.last) begin
                        w_in_idx = '0;
                        w_err    = 1'b1;
                    end else begin
                        w_in_idx = r_in_idx + IW'(1);
                    end
                end
            end
            ST_KICK: begin
                w_state = ST_WAIT;
                w_wdog  = '0;
            end
            ST_WAIT: begin
                if (layer_done) begin
                    w_state   = ST_DRAIN;
                    w_cap     = 1'b1;
                    w_out_idx = '0;
                    w_m_valid = 1'b1;
                    w_m_data  = w_out_elem[0];
                    w_m_last  = (OUT_N == 1);
                end else if (r_wdog == TW'(TIMEOUT - 1)) begin
                    w_state   = ST_LOAD;
                    w_err     = 1'b1;
                    w_s_ready = 1'b1;
                end else begin
                    w_wdog = r_wdog + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (r_m_valid && m.ready) begin
                    if (r_out_idx == OW'(OUT_N - 1)) begin
                        w_state   = ST_LOAD;
                        w_m_valid = 1'b0;
                        w_m_last  = 1'b0;
                        w_s_ready = 1'b1;
                    end else begin
                        w_out_idx = r_out_idx + OW'(1);
                        w_m_data  = r_out_buf[r_out_idx + OW'(1)];
                        w_m_last  = (r_out_idx == OW'(OUT_N - 2));
                    end
                end
            end
            default: w_state = ST_LOAD;
        endcase
        w_busy = (w_state != ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_wdog    <= '0;
            r_s_ready <= 1'b0;
            r_start   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_in_idx  <= w_in_idx;
            r_out_idx <= w_out_idx;
            r_wdog    <= w_wdog;
            r_s_ready <= w_s_ready;
            r_start   <= w_start;
            r_m_valid <= w_m_valid;
            r_m_data  <= w_m_data;
            r_m_last  <= w_m_last;
            r_busy    <= w_busy;
            r_err     <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < IN_N; k++) r_in_buf[k] <= '0;
            for (int j = 0; j < OUT_N; j++) r_out_buf[j] <= '0;
        end else begin
            if (w_in_we) r_in_buf[r_in_idx] <= s.data;
            if (w_cap) begin
                for (int j = 0; j < OUT_N; j++) r_out_buf[j] <= w_out_elem[j];
            end
        end
    end

    assign s.ready     = r_s_ready;
    assign m.valid     = r_m_valid;
    assign m.data      = r_m_data;
    assign m.last      = r_m_last;
    assign layer_start = r_start;
    assign busy        = r_busy;
    assign frame_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_layer1_disc_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer1_disc_stream_adapter
// Brief    : directed bench for the layer-1 stream adapter with a stub layer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer1_disc_stream_adapter;
    localparam int IN_N    = 256;
    localparam int OUT_N   = 128;
    localparam int W       = 16;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer1_disc_stream_adapter_if #(.W(W)) s_if ();
    layer1_disc_stream_adapter_if #(.W(W)) m_if ();

    logic [W*IN_N-1:0]  layer_input_flat;
    logic               layer_start;
    logic [W*OUT_N-1:0] layer_output_flat;
    logic               layer_done;
    logic               busy;
    logic               frame_err;
    logic               stub_done;
    logic               extra_done;
    logic               stub_en;

    assign layer_done = stub_done | extra_done;

    layer1_disc_stream_adapter #(
        .IN_N(IN_N), .OUT_N(OUT_N), .W(W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s                 (s_if),
        .m                 (m_if),
        .layer_input_flat  (layer_input_flat),
        .layer_start       (layer_start),
        .layer_output_flat (layer_output_flat),
        .layer_done        (layer_done),
        .busy              (busy),
        .frame_err         (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int start_count = 0;
    int err_count = 0;

    always @(posedge clk) begin
        if (layer_start) start_count <= start_count + 1;
        if (frame_err)   err_count   <= err_count + 1;
    end

    // Stub layer: done 10 cycles after start; snapshots the input bus mid-run.
    int                stub_cnt;
    logic              stub_act;
    logic [W*IN_N-1:0] snap;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_done <= 1'b0;
            stub_act  <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (layer_start && stub_en) begin
                stub_act <= 1'b1;
                stub_cnt <= 0;
            end else if (stub_act) begin
                stub_cnt <= stub_cnt + 1;
                if (stub_cnt == 5) snap <= layer_input_flat;
                if (stub_cnt == 8) begin
                    stub_done <= 1'b1;
                    stub_act  <= 1'b0;
                end
            end
        end
    end

    task automatic send_frame(input int base, input int n, input int last_at,
                              input bit gapped, input bit expect_kick);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (gapped && (cyc % 3 == 0)) begin
                s_if.valid = 1'b0;
                s_if.last  = 1'b0;
            end else begin
                s_if.valid = 1'b1;
                s_if.data  = W'(base + k);
                s_if.last  = (k == last_at);
            end
            if (s_if.valid && s_if.ready) k++;
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL send_accept: accepted %0d samples, required %0d", k, n);
        end
        if (expect_kick) begin
            checks++;
            if (layer_start !== 1'b1 || s_if.ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL kick_timing: start=%b s_ready=%b busy=%b, required 1 0 1",
                         layer_start, s_if.ready, busy);
            end
        end
    endtask

    task automatic receive(input bit bp, input int stop_at);
        int idx;
        int cyc;
        bit stalled;
        logic [W-1:0] held_d;
        logic held_l;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (layer_done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (layer_done !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: layer_done=%b, required 1 within 500 cycles", layer_done);
            return;
        end
        checks++;
        if (m_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_before_done: m_valid=%b, required 0", m_if.valid);
        end
        cyc = 0;
        while (idx < OUT_N && idx != stop_at && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            m_if.ready = bp ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
            checks++;
            if (m_if.valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid: m_valid=%b at element %0d, required 1", m_if.valid, idx);
                break;
            end else if (m_if.data !== W'(3 * idx) || m_if.last !== (idx == OUT_N - 1)) begin
                errors++;
                $display("FAIL stream_data: element %0d data=%0d last=%b, required data=%0d last=%b",
                         idx, m_if.data, m_if.last, 3 * idx, (idx == OUT_N - 1));
            end
            if (stalled) begin
                checks++;
                if (m_if.data !== held_d || m_if.last !== held_l) begin
                    errors++;
                    $display("FAIL stall_hold: data=%h last=%b, required held data=%h last=%b",
                             m_if.data, m_if.last, held_d, held_l);
                end
            end
            if (m_if.ready) begin
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = m_if.data;
                held_l  = m_if.last;
            end
        end
        if (stop_at < 0) begin
            @(negedge clk);
            m_if.ready = 1'b0;
            checks++;
            if (idx != OUT_N) begin
                errors++;
                $display("FAIL handshake_count: %0d handshakes, required %0d", idx, OUT_N);
            end
            checks++;
            if (s_if.ready !== 1'b1 || m_if.valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_drain: s_ready=%b m_valid=%b busy=%b, required 1 0 0",
                         s_if.ready, m_if.valid, busy);
            end
            if (!bp) begin
                checks++;
                if (cyc != OUT_N) begin
                    errors++;
                    $display("FAIL zero_bubble: drain took %0d cycles, required %0d", cyc, OUT_N);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_if.ready, layer_start, m_if.valid, m_if.last, busy, frame_err} !== 6'b0 ||
            m_if.data !== '0 || layer_input_flat !== '0) begin
            errors++;
            $display("FAIL reset_values: ctrl=%b data=%h flat_nonzero=%b, required ctrl=000000 data=0000 flat_nonzero=0",
                     {s_if.ready, layer_start, m_if.valid, m_if.last, busy, frame_err},
                     m_if.data, (layer_input_flat != '0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: s_ready=%b, required 0", s_if.ready);
        end
        @(negedge clk);
        checks++;
        if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%b busy=%b, required 1 0", s_if.ready, busy);
        end
    endtask

    task automatic test_basic_frame();
        int s0;
        int e0;
        int bad;
        s0 = start_count;
        e0 = err_count;
        send_frame(0, IN_N, IN_N - 1, 1'b0, 1'b1);
        receive(1'b0, -1);
        checks++;
        if (snap[200*W +: W] !== 16'd200) begin
            errors++;
            $display("FAIL basic_elem200: got %0d, required 200", snap[200*W +: W]);
        end
        bad = 0;
        for (int k = 0; k < IN_N; k++) if (snap[k*W +: W] !== W'(k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_packing: %0d wrong elements, required 0", bad);
        end
        checks++;
        if (start_count - s0 != 1 || err_count != e0) begin
            errors++;
            $display("FAIL basic_pulses: starts=%0d errs=%0d, required 1 0", start_count - s0, err_count - e0);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int bad;
        s0 = start_count;
        send_frame(16'h0400, IN_N, IN_N - 1, 1'b1, 1'b1);
        receive(1'b1, -1);
        bad = 0;
        for (int k = 0; k < IN_N; k++) if (snap[k*W +: W] !== W'(16'h0400 + k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gapped_packing: %0d wrong elements, required 0", bad);
        end
        checks++;
        if (start_count - s0 != 1) begin
            errors++;
            $display("FAIL bp_starts: %0d starts, required 1", start_count - s0);
        end
    endtask

    task automatic test_early_last();
        int s0;
        int e0;
        int bad;
        s0 = start_count;
        e0 = err_count;
        send_frame(0, 101, 100, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (err_count - e0 != 1 || start_count != s0) begin
            errors++;
            $display("FAIL early_last_pulses: errs=%0d starts=%0d, required 1 0", err_count - e0, start_count - s0);
        end
        checks++;
        if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL early_last_state: s_ready=%b busy=%b, required 1 0", s_if.ready, busy);
        end
        send_frame(16'h0100, IN_N, IN_N - 1, 1'b0, 1'b1);
        receive(1'b0, -1);
        bad = 0;
        for (int k = 0; k < IN_N; k++) if (snap[k*W +: W] !== W'(16'h0100 + k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL recovery_packing: %0d wrong elements, required 0", bad);
        end
    endtask

    task automatic test_timeout();
        int n;
        int e0;
        stub_en = 1'b0;
        e0 = err_count;
        send_frame(16'h0600, IN_N, IN_N - 1, 1'b0, 1'b1);
        n = 0;
        while (frame_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TIMEOUT || n > TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_latency: frame_err after %0d cycles, required %0d..%0d", n, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: s_ready=%b busy=%b, required 1 0", s_if.ready, busy);
        end
        @(negedge clk);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (m_if.valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL late_done: m_valid=%b busy=%b, required 0 0", m_if.valid, busy);
            end
        end
        checks++;
        if (err_count - e0 != 1) begin
            errors++;
            $display("FAIL timeout_errs: %0d pulses, required 1", err_count - e0);
        end
        stub_en = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        send_frame(16'h0700, IN_N, IN_N - 1, 1'b0, 1'b1);
        receive(1'b0, 40);
        @(negedge clk);
        m_if.ready = 1'b0;
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== 16'd120) begin
            errors++;
            $display("FAIL drain_elem40: valid=%b data=%0d, required 1 120", m_if.valid, m_if.data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_if.ready, layer_start, m_if.valid, m_if.last, busy, frame_err} !== 6'b0 ||
            m_if.data !== '0 || layer_input_flat !== '0) begin
            errors++;
            $display("FAIL midrun_reset: ctrl=%b data=%h flat_nonzero=%b, required ctrl=000000 data=0000 flat_nonzero=0",
                     {s_if.ready, layer_start, m_if.valid, m_if.last, busy, frame_err},
                     m_if.data, (layer_input_flat != '0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_ready: s_ready=%b, required 1", s_if.ready);
        end
        send_frame(16'h0800, IN_N, IN_N - 1, 1'b0, 1'b1);
        receive(1'b0, -1);
        checks++;
        if (snap[0 +: W] !== 16'h0800 || snap[255*W +: W] !== 16'h08FF) begin
            errors++;
            $display("FAIL midrun_frame: elem0=%h elem255=%h, required 0800 08ff", snap[0 +: W], snap[255*W +: W]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
        extra_done = 1'b0;
        stub_en    = 1'b1;
        for (int j = 0; j < OUT_N; j++) layer_output_flat[W*j +: W] = W'(3 * j);
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_early_last();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/layer1_disc_stream_adapter.md
# layer1_disc_stream_adapter

Streaming front/back end for the discriminator's first dense layer (256 in → 128 out, Q8.8). Accepts a 256-sample frame on a valid/ready slave stream, packs it into the layer's flattened input bus, issues the one-cycle `start`, and waits for `done`. It then captures the 128-element flattened result and replays it on a valid/ready master stream. The block is the initiator side of the layer's start/done protocol and sits between the pixel source and the layer core.

## Interface
- `IN_N`, 256, elements per input frame.
- `OUT_N`, 128, elements per output frame.
- `W`, 16, element width, signed Q8.8.
- `TIMEOUT`, 40000, maximum number of WAIT cycles before the frame is aborted.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  W  input sample.
- `s_last`  in  1  marks the final sample of a frame.
- `s_ready`  out  1  adapter accepts a sample.
- `layer_input_flat`  out  W*IN_N  element k at bits [W*k+W-1 : W*k].
- `layer_start`  out  1  one-cycle start pulse to the layer.
- `layer_output_flat`  in  W*OUT_N  layer result, same packing.
- `layer_done`  in  1  one-cycle completion pulse from the layer.
- `m_valid`  out  1  output element valid.
- `m_data`  out  W  output element.
- `m_last`  out  1  asserted with element OUT_N-1.
- `m_ready`  in  1  downstream accepts an element.
- `busy`  out  1  high in KICK, WAIT and DRAIN.
- `frame_err`  out  1  one-cycle error pulse.

## Operation
- States: LOAD → KICK → WAIT → DRAIN → LOAD.
- **LOAD**
  - `s_ready`=1.
  - On each handshake (`s_valid && s_ready`), the sample is written to element `in_idx` and `in_idx` increments. The first sample of a frame is element 0.
  - If `s_last` is set while `in_idx` < IN_N-1: `frame_err` pulses, `in_idx` returns to 0, and the state stays LOAD. The partial frame is discarded and buffer contents are don't-care.
  - On the beat with `in_idx` == IN_N-1: go to KICK. If `s_last` is 0 on that beat, `frame_err` still pulses but the frame proceeds.
- **KICK**
  - `layer_start`=1 for exactly this one cycle; `s_ready`=0.
  - Next state is WAIT, with the watchdog cleared.
- **WAIT**
  - `layer_input_flat` is held bit-stable, because the layer reads it combinationally throughout its MAC run.
  - When `layer_done`=1, latch `layer_output_flat` into an internal buffer, set `out_idx`=0, and go to DRAIN.
  - If the watchdog reaches TIMEOUT-1 without `layer_done`: `frame_err` pulses and the state returns to LOAD.
- **DRAIN**
  - `m_valid`=1, `m_data`=buffer[`out_idx`], `m_last`=(`out_idx`==OUT_N-1).
  - On each handshake (`m_valid && m_ready`), `out_idx` increments.
  - After the handshake on the last element, the state returns to LOAD.
- `layer_done` outside WAIT is ignored.
- No frame overlap: `s_ready`=0 in KICK, WAIT and DRAIN.
- No arithmetic on data. Samples and results pass bit-exact.

## Timing
- Reset values:
  - `s_ready`, `layer_start`, `m_valid`, `m_last`, `busy`, `frame_err` = 0.
  - `m_data` = 0 and `layer_input_flat` = 0.
  - State LOAD, `in_idx`=`out_idx`=0.
  - `s_ready` rises in the first cycle after `rst` deasserts.
- All outputs are registered.
- The 256th input handshake at edge N gives `layer_start`=1 during cycle N+1 (KICK).
- `layer_done` sampled high at edge M gives `m_valid`=1 in the cycle after M, carrying element 0.
- AXI-style holding rule: while `m_valid && !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops mid-frame without a handshake.
- Zero-bubble stream at full throughput: `m_ready` held at 1 yields 128 consecutive beats.
- After the final output handshake at edge K, `s_ready`=1 in cycle K+1.
- Throughput per frame is ≥ IN_N + 1 + layer latency + OUT_N cycles.
- Reset mid-operation, in any state: immediate return to reset values. The in-flight frame is lost, and the layer core shares `rst`.

## Test plan
- **Basic frame with stub layer.** Input sample k = k. The stub asserts `done` 10 cycles after `start` with output j = 3·j.
  - `layer_input_flat` element 200 must equal 200 while waiting.
  - Exactly one `start` pulse.
  - `m_data` must read 0, 3, …, 381 in order, with `m_last` only on 381.
- **Backpressure.** Same frame with `m_ready` pattern 1,0,0,1 repeating.
  - Exactly 128 handshakes, no duplicates or drops, `m_data` stable during stalls.
  - `s_valid` gapped every third cycle must not corrupt the input packing.
- **Early `s_last`.** `s_last` on beat 100.
  - `frame_err` pulses once, with no `start`.
  - The following 256 beats (0x0100…) form a correct frame.
- **Timeout.** TIMEOUT=50 and the stub never asserts `done`.
  - `frame_err` pulses 50 cycles after KICK, then `s_ready`=1.
  - A late `done` arriving afterwards is ignored (`m_valid` stays 0).
- **Integration with the real layer-1 core.** All-zero input frame.
  - 128 outputs equal the bias table entries, bias[j], in order.
  - Total latency from `start` to first `m_valid` is ≈ 32770 cycles.
- **Reset mid-run.** Assert `rst` during DRAIN at element 40.
  - All outputs go to their reset values immediately.
  - A new frame afterwards completes normally from element 0.
